muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit with built-in HI/LO registers; replaces the separate

---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with built-in HI/LO registers and a start/busy/done handshake.
// Define MULDIV_UNSIGNED_EN to honour op[0] (multu/divu); otherwise every op is treated as signed.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_main;
  logic               neg_rem;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   divisor;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  logic signed_op;
`ifdef MULDIV_UNSIGNED_EN
  assign signed_op = ~op[0];
`else
  logic unused_op;
  assign signed_op = 1'b1;
  assign unused_op = op[0];
`endif

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = signed_op & a[WIDTH-1];
  assign b_neg = signed_op & b[WIDTH-1];
  assign a_mag = cond_neg(a, a_neg);
  assign b_mag = cond_neg(b, b_neg);

  // Multiply step: conditional add of the multiplicand into the upper half, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: shift the remainder/quotient pair left, keep the difference if non-negative.
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {acc, 1'b0};
  assign div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, divisor};
  assign div_next  = div_diff[WIDTH] ? div_shift[2*WIDTH-1:0]
                                     : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed, rem_fixed;
  assign prod_fixed = cond_neg2(acc, neg_main);
  assign quot_fixed = cond_neg(acc[WIDTH-1:0], neg_main);
  assign rem_fixed  = cond_neg(acc[2*WIDTH-1:WIDTH], neg_rem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_wr) hi <= wdata;
          if (lo_wr) lo <= wdata;
          if (start) begin
            is_div   <= op[1];
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            cnt      <= CNT_W'(WIDTH);
            busy     <= 1'b1;
            if (op[1] && b == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo <= quot_fixed;
            hi <= rem_fixed;
          end else begin
            hi <= prod_fixed[2*WIDTH-1:WIDTH];
            lo <= prod_fixed[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always reloaded on an accepted start.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      acc     <= {{WIDTH{1'b0}}, a_mag};
      divisor <= b_mag;
    end else if (state == CALC) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit (WIDTH=32) against a plain-arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         hi_wr, lo_wr;
  logic [W-1:0] wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi, m_lo;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit is_unsigned(input logic [1:0] o);
`ifdef MULDIV_UNSIGNED_EN
    return o[0];
`else
    return 1'b0;
`endif
  endfunction

  // Reference: 64-bit arithmetic; SV division truncates toward zero, remainder follows the dividend.
  task automatic model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output bit dz);
    longint sx, sy, q, r;
    logic [63:0] p;
    dz = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o[1]) begin
      if (is_unsigned(o)) p = {32'b0, x} * {32'b0, y};
      else p = sx * sy;
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (y == '0) begin
      dz = 1'b1;
    end else if (is_unsigned(o)) begin
      m_lo = x / y;
      m_hi = x % y;
    end else begin
      q = sx / sy;
      r = sx % sy;
      m_lo = q[31:0];
      m_hi = r[31:0];
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit whi, input bit wlo, input logic [W-1:0] wd,
                        input bit interfere, input string tag);
    int n;
    int idle_seen;
    bit dz;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    hi_wr = whi; lo_wr = wlo; wdata = wd;
    if (whi) m_hi = wd;
    if (wlo) m_lo = wd;
    model_op(o, x, y, dz);
    @(posedge clk); #1;
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    a = $urandom; b = $urandom; wdata = $urandom;
    check({tag, ":busy_e0"}, busy, 1);
    n = 0;
    idle_seen = 0;
    while (!done && n < 100) begin
      start = interfere && n == 4;
      hi_wr = interfere && n == 9;
      @(posedge clk); #1;
      n++;
      if (!busy) idle_seen++;
    end
    start = 1'b0;
    hi_wr = 1'b0;
    check({tag, ":latency"}, n, dz ? 0 : W + 1);
    check({tag, ":busy_gap"}, idle_seen, 0);
    check({tag, ":div_zero"}, div_zero, dz);
    check({tag, ":hi"}, hi, m_hi);
    check({tag, ":lo"}, lo, m_lo);
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, done, 0);
    check({tag, ":busy_end"}, busy, 0);
  endtask

  task automatic write_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
    @(negedge clk); hi_wr = 1'b1; wdata = h;
    @(negedge clk); hi_wr = 1'b0; lo_wr = 1'b1; wdata = l;
    @(negedge clk); lo_wr = 1'b0;
    m_hi = h;
    m_lo = l;
    check("mthi", hi, h);
    check("mtlo", lo, l);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rw;
    logic [1:0]   ro;
    int sel;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; wdata = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk); rst = 1'b0;
    m_hi = '0; m_lo = '0;

    run_op(2'b00, 32'd7, 32'hFFFFFFFD, 0, 0, '0, 0, "mult_7x-3");
    run_op(2'b10, 32'd100, 32'd7, 0, 0, '0, 0, "div_100_7");
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, 0, '0, 0, "div_-7_2");
    write_hilo(32'h0000AAAA, 32'h00005555);
    run_op(2'b10, 32'd5, 32'd0, 0, 0, '0, 0, "div_by_zero");
    run_op(2'b01, 32'hFFFFFFFF, 32'd2, 0, 0, '0, 0, "multu");
    run_op(2'b11, 32'hFFFFFFFF, 32'd2, 0, 0, '0, 0, "divu");
    run_op(2'b00, 32'd7, 32'hFFFFFFFD, 0, 0, '0, 1, "mult_interfere");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, '0, 0, "div_min_-1");
    run_op(2'b00, 32'h80000000, 32'h80000000, 0, 0, '0, 0, "mult_min_min");
    run_op(2'b10, 32'h80000000, 32'd1, 0, 0, '0, 0, "div_min_1");
    run_op(2'b10, 32'd0, 32'hFFFFFFF3, 0, 0, '0, 0, "div_zero_dividend");
    run_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 1, 1, 32'hDEADBEEF, 0, "mult_wr_same_cycle");
    run_op(2'b10, 32'd9, 32'd0, 1, 0, 32'hCAFEF00D, 0, "dz_wr_same_cycle");

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    @(negedge clk); rst = 1'b0;
    m_hi = '0; m_lo = '0;
    run_op(2'b10, 32'd1000, 32'd3, 0, 0, '0, 0, "after_abort");

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      ra = (sel == 0) ? 32'h80000000 : (sel == 1) ? 32'hFFFFFFFF : W'($urandom);
      sel = $urandom_range(0, 7);
      rb = (sel == 0) ? '0 : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? W'($urandom_range(1, 15))
                                                                     : W'($urandom);
      rw = $urandom;
      run_op(ro, ra, rb, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, rw,
             $urandom_range(0, 5) == 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
